// File: rtl/run_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | run_sequencer: clears data memory, preloads operands, launches the CPU, |
// | watches for halt (with watchdog) and streams a window of results out.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module run_sequencer #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int CW        = 16,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 50000,
  parameter int RES_BASE  = 4,
  parameter int RES_N     = 3
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          go,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          cpu_start,
  input  logic          cpu_halt,
  output logic          mem_own,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_data,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  localparam int IDX_W = $clog2(RES_N + 1);
  localparam int LW    = $clog2(START_CYC + 1);
  localparam logic [AW-1:0]    BASE        = AW'(RES_BASE);
  localparam logic [CW-1:0]    TMO         = CW'(TIMEOUT);
  localparam logic [CW-1:0]    CMAX        = '1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(RES_N - 1);
  localparam logic [LW-1:0]    LAUNCH_LAST = LW'(START_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_LAUNCH = 3'd3,
    S_RUN    = 3'd4,
    S_DUMP   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t           state;
  logic [AW-1:0]    clr_addr;
  logic [IDX_W-1:0] idx;
  logic [LW-1:0]    lcnt;
  logic             ld_fire;
  logic             res_fire;

  assign ld_fire  = ld_valid & ld_ready;
  assign res_fire = res_valid & res_ready;
  assign res_addr = BASE + AW'(idx);
  assign res_data = mem_rd_data;

  // Reset gates the write strobe combinationally so an aborted run never
  // commits the word that was in flight on the reset cycle.
  always_comb begin
    mem_addr    = res_addr;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      S_CLEAR: begin
        mem_addr  = clr_addr;
        mem_wr_en = 1'b1;
      end
      S_LOAD: begin
        mem_addr    = ld_addr;
        mem_wr_en   = ld_valid;
        mem_wr_data = ld_data;
      end
      default: ;
    endcase
    if (Reset) mem_wr_en = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= S_IDLE;
      clr_addr    <= '0;
      idx         <= '0;
      lcnt        <= '0;
      cpu_start   <= 1'b1;
      mem_own     <= 1'b0;
      ld_ready    <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state       <= S_CLEAR;
            mem_own     <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            clr_addr    <= '0;
            idx         <= '0;
          end
        end
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state    <= S_LOAD;
            ld_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_fire && ld_last) begin
            state    <= S_LAUNCH;
            ld_ready <= 1'b0;
            mem_own  <= 1'b0;
            lcnt     <= '0;
          end
        end
        S_LAUNCH: begin
          lcnt <= lcnt + 1'b1;
          if (lcnt == LAUNCH_LAST) begin
            state     <= S_RUN;
            cpu_start <= 1'b0;
          end
        end
        S_RUN: begin
          // Halt is checked first so it wins over a coincident watchdog expiry.
          if (cpu_halt || cycle_count == TMO) begin
            state     <= S_DUMP;
            cpu_start <= 1'b1;
            mem_own   <= 1'b1;
            res_valid <= 1'b1;
            idx       <= '0;
            timeout   <= ~cpu_halt;
          end else if (cycle_count != CMAX) begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        S_DUMP: begin
          if (res_fire) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state     <= S_DONE;
              res_valid <= 1'b0;
              mem_own   <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_run_sequencer: scoreboard bench with a data-memory and CPU model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_run_sequencer;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [NI-1:0] go, ld_valid, ld_ready, ld_last, cpu_start, cpu_halt, mem_own;
  logic [NI-1:0] mem_wr_en, res_valid, res_ready, busy, done, timeout, cpu_we, fill;
  logic [NI-1:0][7:0] ld_addr, ld_data, mem_addr, mem_wr_data, mem_rd_data;
  logic [NI-1:0][7:0] res_addr, res_data, peek_addr, peek_data;
  logic [NI-1:0][15:0] cycle_count, halt_at;

  typedef struct {
    int         inst;
    logic [7:0] addr;
    logic [7:0] data;
  } res_t;
  res_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instance 0 covers the main flows; instance 1 has a result window that wraps.
  for (genvar gi = 0; gi < NI; gi++) begin : g_env
    localparam int RB = (gi == 0) ? 4 : 254;
    localparam int RN = (gi == 0) ? 3 : 4;
    logic [7:0]  mem [256];
    logic [15:0] cpu_cnt;

    run_sequencer #(
      .DW(8), .AW(8), .CW(16), .START_CYC(2), .TIMEOUT(100), .RES_BASE(RB), .RES_N(RN)
    ) u_dut (
      .CLK(clk), .Reset(rst), .go(go[gi]),
      .ld_valid(ld_valid[gi]), .ld_ready(ld_ready[gi]), .ld_addr(ld_addr[gi]),
      .ld_data(ld_data[gi]), .ld_last(ld_last[gi]),
      .cpu_start(cpu_start[gi]), .cpu_halt(cpu_halt[gi]),
      .mem_own(mem_own[gi]), .mem_addr(mem_addr[gi]), .mem_wr_en(mem_wr_en[gi]),
      .mem_wr_data(mem_wr_data[gi]), .mem_rd_data(mem_rd_data[gi]),
      .res_valid(res_valid[gi]), .res_ready(res_ready[gi]), .res_addr(res_addr[gi]),
      .res_data(res_data[gi]), .busy(busy[gi]), .done(done[gi]),
      .timeout(timeout[gi]), .cycle_count(cycle_count[gi])
    );

    assign mem_rd_data[gi] = mem[mem_addr[gi]];
    assign peek_data[gi]   = mem[peek_addr[gi]];
    assign cpu_halt[gi]    = !cpu_start[gi] && (cpu_cnt == halt_at[gi]);

    // CPU model: counts its own run cycles and stores 0x55 to addr 4 early on.
    always @(posedge clk) begin
      cpu_cnt <= cpu_start[gi] ? 16'd0 : cpu_cnt + 16'd1;
      if (fill[gi]) begin
        for (int a = 0; a < 256; a++) mem[a] <= 8'hFF;
      end else if (mem_own[gi] && mem_wr_en[gi]) begin
        mem[mem_addr[gi]] <= mem_wr_data[gi];
      end else if (!mem_own[gi] && cpu_we[gi] && !cpu_start[gi] && cpu_cnt == 16'd5) begin
        mem[4] <= 8'h55;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] a, input logic [7:0] d);
    res_t e;
    e.inst = i;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_go(input int i);
    go[i] = 1'b1;
    tick();
    go[i] = 1'b0;
  endtask

  task automatic load_word(input int i, input logic [7:0] a, input logic [7:0] d, input logic last);
    int c = 0;
    ld_addr[i]  = a;
    ld_data[i]  = d;
    ld_last[i]  = last;
    ld_valid[i] = 1'b1;
    while (!ld_ready[i] && c < 1000) begin
      tick();
      c++;
    end
    check("load_accept_wait", int'(c < 1000), 1);
    tick();
    ld_valid[i] = 1'b0;
    ld_last[i]  = 1'b0;
  endtask

  task automatic wait_dump(input int i);
    int c = 0;
    while (!res_valid[i] && c < 1000) begin
      tick();
      c++;
    end
    check("dump_entry_wait", int'(res_valid[i]), 1);
  endtask

  task automatic wait_done(input int i);
    int c = 0;
    while (!done[i] && c < 1000) begin
      tick();
      c++;
    end
    check("done_wait", int'(done[i]), 1);
  endtask

  // Monitor: pops the scoreboard on every result handshake and checks that a
  // stalled word holds its address and data.
  initial begin
    logic [NI-1:0]      stalled;
    logic [NI-1:0][7:0] h_addr, h_data;
    res_t               e;
    stalled = '0;
    h_addr  = '0;
    h_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (res_valid[i]) begin
          if (stalled[i]) begin
            check("stall_res_addr", res_addr[i], h_addr[i]);
            check("stall_res_data", res_data[i], h_data[i]);
          end
          if (res_ready[i]) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_result: inst %0d got addr 0x%0h data 0x%0h, required none",
                       i, res_addr[i], res_data[i]);
            end else begin
              e = exp_q.pop_front();
              check("res_inst", i, e.inst);
              check("res_addr", res_addr[i], e.addr);
              check("res_data", res_data[i], e.data);
            end
          end
          stalled[i] = !res_ready[i];
          h_addr[i]  = res_addr[i];
          h_data[i]  = res_data[i];
        end else begin
          stalled[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int pat[5];
    int nx;
    rst = 1'b1;  go = '0;  ld_valid = '0;  ld_last = '0;  ld_addr = '0;  ld_data = '0;
    res_ready = '1;  halt_at = '1;  cpu_we = '0;  fill = '0;  peek_addr = '0;
    repeat (3) tick();
    rst = 1'b0;

    for (int i = 0; i < NI; i++) begin
      check("rst_cpu_start", cpu_start[i], 1);
      check("rst_busy", busy[i], 0);
      check("rst_done", done[i], 0);
      check("rst_timeout", timeout[i], 0);
      check("rst_cycle_count", cycle_count[i], 0);
      check("rst_ld_ready", ld_ready[i], 0);
      check("rst_res_valid", res_valid[i], 0);
      check("rst_mem_own", mem_own[i], 0);
      check("rst_mem_wr_en", mem_wr_en[i], 0);
    end

    // Reset lands while CLEAR is writing address 0x40.
    fill[0] = 1'b1;
    tick();
    fill[0] = 1'b0;
    pulse_go(0);
    begin
      int c = 0;
      while (!(busy[0] && mem_wr_en[0] && mem_addr[0] == 8'h40) && c < 400) begin
        tick();
        c++;
      end
      check("t1_reach_addr40", int'(c < 400), 1);
    end
    rst = 1'b1;
    #1;
    check("t1_wr_en_during_reset", mem_wr_en[0], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t1_busy", busy[0], 0);
    check("t1_cpu_start", cpu_start[0], 1);
    check("t1_mem_wr_en", mem_wr_en[0], 0);
    check("t1_mem_own", mem_own[0], 0);
    peek_addr[0] = 8'h40;
    #1;
    check("t1_addr40_untouched", peek_data[0], 8'hFF);
    peek_addr[0] = 8'h3F;
    #1;
    check("t1_addr3f_cleared", peek_data[0], 8'h00);

    // Normal run: CPU halts after 37 run cycles, having written 0x55 to addr 4.
    halt_at[0] = 16'd37;
    cpu_we[0]  = 1'b1;
    push(0, 8'd4, 8'h55);
    push(0, 8'd5, 8'h00);
    push(0, 8'd6, 8'h00);
    pulse_go(0);
    check("t2_busy", busy[0], 1);
    check("t2_done_cleared", done[0], 0);
    load_word(0, 8'd0, 8'h00, 1'b0);
    tick();
    load_word(0, 8'd1, 8'h7F, 1'b0);
    load_word(0, 8'd1, 8'h01, 1'b0);
    load_word(0, 8'd2, 8'h03, 1'b1);
    wait_dump(0);
    check("t2_cycle_count_dump", cycle_count[0], 37);
    check("t2_timeout", timeout[0], 0);
    check("t2_cpu_frozen", cpu_start[0], 1);
    wait_done(0);
    check("t2_busy_after", busy[0], 0);
    check("t2_cycle_count_done", cycle_count[0], 37);
    peek_addr[0] = 8'd1;
    #1;
    check("t2_dup_addr_last_wins", peek_data[0], 8'h01);
    peek_addr[0] = 8'd2;
    #1;
    check("t2_addr2", peek_data[0], 8'h03);

    // Pre-filled memory is cleared; only the single loaded word survives.
    fill[0] = 1'b1;
    tick();
    fill[0]    = 1'b0;
    cpu_we[0]  = 1'b0;
    halt_at[0] = 16'd10;
    push(0, 8'd4, 8'h00);
    push(0, 8'd5, 8'h00);
    push(0, 8'd6, 8'h00);
    pulse_go(0);
    load_word(0, 8'd7, 8'h12, 1'b1);
    wait_done(0);
    for (int a = 0; a < 256; a++) begin
      peek_addr[0] = 8'(a);
      #1;
      check("t3_mem_after_clear", peek_data[0], (a == 7) ? 8'h12 : 8'h00);
    end

    // CPU never halts: watchdog fires at 100 cycles; go during DUMP is ignored.
    halt_at[0]   = 16'hFFFF;
    cpu_we[0]    = 1'b1;
    res_ready[0] = 1'b0;
    push(0, 8'd4, 8'h55);
    push(0, 8'd5, 8'h00);
    push(0, 8'd6, 8'h00);
    pulse_go(0);
    load_word(0, 8'd0, 8'hAA, 1'b1);
    wait_dump(0);
    check("t4_timeout", timeout[0], 1);
    check("t4_cycle_count", cycle_count[0], 100);
    pulse_go(0);
    check("t4_go_ignored_busy", busy[0], 1);
    check("t4_go_ignored_addr", res_addr[0], 4);
    res_ready[0] = 1'b1;
    wait_done(0);
    check("t4_timeout_sticky", timeout[0], 1);

    // Back-pressure on the result stream.
    halt_at[0]   = 16'd20;
    res_ready[0] = 1'b0;
    push(0, 8'd4, 8'h55);
    push(0, 8'd5, 8'h00);
    push(0, 8'd6, 8'h00);
    pulse_go(0);
    check("t5_timeout_cleared", timeout[0], 0);
    load_word(0, 8'd3, 8'h33, 1'b1);
    wait_dump(0);
    pat = '{1, 0, 0, 1, 1};
    nx  = 0;
    for (int k = 0; k < 5; k++) begin
      res_ready[0] = pat[k][0];
      tick();
      nx += pat[k];
      check("t5_done_after_step", done[0], int'(nx == 3));
      check("t5_valid_after_step", res_valid[0], int'(nx < 3));
    end
    res_ready[0] = 1'b1;

    // Wrapping result window; halt coincides with the watchdog limit.
    halt_at[1] = 16'd100;
    push(1, 8'd254, 8'hA1);
    push(1, 8'd255, 8'hB2);
    push(1, 8'd0, 8'hC3);
    push(1, 8'd1, 8'hD4);
    pulse_go(1);
    load_word(1, 8'd254, 8'hA1, 1'b0);
    load_word(1, 8'd255, 8'hB2, 1'b0);
    load_word(1, 8'd0, 8'hC3, 1'b0);
    load_word(1, 8'd1, 8'hD4, 1'b1);
    wait_dump(1);
    check("t6_halt_wins_timeout", timeout[1], 0);
    check("t6_cycle_count", cycle_count[1], 100);
    wait_done(1);
    check("t6_timeout_after", timeout[1], 0);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
